mem_cmd_responder: RTL and testbench



---
 rtl/mem_cmd_responder_pkg.sv | 24 ++
 rtl/mem_resp_return_buf.sv | 80 ++++++++
 rtl/mem_cmd_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_cmd_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cmd_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_cmd_responder_pkg
// Shared definitions for the memory-side command responder:
//   - MEM_CMD_WIDTH : width of a MemoryCommand word on the command FIFO
//   - mem_cmd_t     : MemoryCommand layout {address, length, read_not_write}
//   - state_t       : responder FSM encodings (IDLE, WRITE, READ)
// -----------------------------------------------------------------------------
package mem_cmd_responder_pkg;

    localparam int MEM_CMD_WIDTH = 65;

    typedef struct packed {
        logic [31:0] address;         // word address, truncated by the responder
        logic [31:0] length;          // transfer length in words
        logic        read_not_write;  // 1 = read, 0 = write
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

endpackage : mem_cmd_responder_pkg

// File: rtl/mem_resp_return_buf.sv
// -----------------------------------------------------------------------------
// mem_resp_return_buf
// Synchronous first-word-fall-through FIFO used as the read return buffer.
// The head word is presented on o_data whenever o_valid is high; i_pop on an
// empty buffer is ignored. Pushing into a full buffer without a simultaneous
// pop is illegal and flagged by an assertion (the caller's credit scheme must
// prevent it).
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail
//   i_push_data  : data to store
//   i_pop        : consume the head word (ignored when empty)
//   o_valid      : buffer not empty
//   o_data       : head word (0 when empty)
//   o_count      : number of stored words
// -----------------------------------------------------------------------------
module mem_resp_return_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, and a reset-free array maps onto RAM cells.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    overflow_check : assert property (@(posedge clk) disable iff (reset)
        !(i_push && !w_do_pop && (r_count == CNT_W'(DEPTH))));

endmodule : mem_resp_return_buf

// File: rtl/mem_cmd_responder.sv
// -----------------------------------------------------------------------------
// mem_cmd_responder
// Memory-side endpoint of the arbiter command protocol. Executes MemoryCommand
// words against a single-port synchronous SRAM: write commands sink words from
// the write FIFO into the SRAM, read commands issue SRAM reads and return the
// data through a credit-controlled FWFT return buffer.
//
// Optional feature: define MEM_CMD_RESPONDER_STATS_EN to add the wrapping
// 32-bit counters stat_cmds, stat_wr_words and stat_rd_words.
//
// Ports:
//   clk, reset                   : memory clock, async active-high reset
//   cmd_ready/enable/data        : command handshake (65-bit MemoryCommand)
//   write_ready/enable/data      : write-word handshake
//   read_ready/enable/data       : read-word handshake (responder is source)
//   mem_addr, mem_wr_en,
//   mem_wr_data, mem_rd_en,
//   mem_rd_data                  : SRAM interface
//   busy                         : not IDLE, or reads in flight / buffered
//   stat_*                       : statistics (MEM_CMD_RESPONDER_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_cmd_responder
    import mem_cmd_responder_pkg::*;
#(
    parameter int MEM_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 2,   // >= 1
    parameter int RD_BUF_DEPTH = 4    // power of 2, >= READ_LATENCY + 1
) (
`ifdef MEM_CMD_RESPONDER_STATS_EN
    output logic [31:0]            stat_cmds,
    output logic [31:0]            stat_wr_words,
    output logic [31:0]            stat_rd_words,
`endif
    input  logic                     clk,
    input  logic                     reset,
    output logic                     cmd_ready,
    input  logic                     cmd_enable,
    input  logic [MEM_CMD_WIDTH-1:0] cmd_data,
    output logic                     write_ready,
    input  logic                     write_enable,
    input  logic [MEM_WIDTH-1:0]     write_data,
    input  logic                     read_ready,
    output logic                     read_enable,
    output logic [MEM_WIDTH-1:0]     read_data,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic                     mem_wr_en,
    output logic [MEM_WIDTH-1:0]     mem_wr_data,
    output logic                     mem_rd_en,
    input  logic [MEM_WIDTH-1:0]     mem_rd_data,
    output logic                     busy
);

    localparam int CNT_W = $clog2(RD_BUF_DEPTH + 1);

    state_t                  r_state;
    state_t                  w_next_state;
    mem_cmd_t                w_cmd;
    logic [ADDR_WIDTH-1:0]   r_addr;       // next address to write/read
    logic [ADDR_WIDTH-1:0]   r_wr_addr;    // address of the registered write strobe
    logic [31:0]             r_remaining;
    logic                    r_mem_wr_en;
    logic [MEM_WIDTH-1:0]    r_mem_wr_data;
    logic [READ_LATENCY-1:0] r_rd_pipe;    // one tag per read in flight
    logic [CNT_W-1:0]        w_inflight;
    logic [CNT_W-1:0]        w_buf_count;
    logic [CNT_W-1:0]        w_used;
    logic                    w_credit_ok;
    logic                    w_cmd_hs;
    logic                    w_wr_hs;
    logic                    w_rd_issue;
    logic                    w_ret_push;
    logic                    w_unused_addr_bits;

    assign w_cmd = cmd_data;
    // Upper command address bits are dropped by design.
    assign w_unused_addr_bits = ^w_cmd.address[31:ADDR_WIDTH];

    assign w_cmd_hs   = cmd_enable && cmd_ready;
    assign w_wr_hs    = write_enable && write_ready;
    assign w_rd_issue = mem_rd_en;
    assign w_ret_push = r_rd_pipe[READ_LATENCY-1];

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch); blocking '=' is
    // correct here because later statements must see earlier results.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_rd_pipe[i]);
        end
    end

    // Credit uses only registered counts, so a pop frees credit one cycle later.
    assign w_used      = w_inflight + w_buf_count;
    assign w_credit_ok = (w_used < CNT_W'(RD_BUF_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        write_ready  = 1'b0;
        mem_rd_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = !reset;
                if (cmd_enable && !reset && (w_cmd.length != 32'd0)) begin
                    w_next_state = w_cmd.read_not_write ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                write_ready = 1'b1;
                if (write_enable && (r_remaining == 32'd1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                mem_rd_en = w_credit_ok;
                if (w_credit_ok && (r_remaining == 32'd1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_wr_addr     <= '0;
            r_remaining   <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= '0;
            r_rd_pipe     <= '0;
        end else begin
            r_mem_wr_en <= w_wr_hs;
            r_rd_pipe   <= (r_rd_pipe << 1) | READ_LATENCY'(w_rd_issue);
            if (w_cmd_hs) begin
                r_addr      <= w_cmd.address[ADDR_WIDTH-1:0];
                r_remaining <= w_cmd.length;
            end else if (w_wr_hs) begin
                r_wr_addr     <= r_addr;
                r_mem_wr_data <= write_data;
                r_addr        <= r_addr + ADDR_WIDTH'(1);
                r_remaining   <= r_remaining - 32'd1;
            end else if (w_rd_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - 32'd1;
            end
        end
    end

    // The registered write strobe fires in the cycle after the last write
    // handshake, when the FSM is IDLE, so it never overlaps READ addressing.
    assign mem_addr    = (r_state == ST_READ) ? r_addr : r_wr_addr;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_data = r_mem_wr_data;

    mem_resp_return_buf #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (RD_BUF_DEPTH)
    ) u_return_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_ret_push),
        .i_push_data (mem_rd_data),
        .i_pop       (read_ready),
        .o_valid     (read_enable),
        .o_data      (read_data),
        .o_count     (w_buf_count)
    );

    assign busy = (r_state != ST_IDLE) || (r_rd_pipe != '0) || (w_buf_count != '0);

`ifdef MEM_CMD_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cmds     <= '0;
            stat_wr_words <= '0;
            stat_rd_words <= '0;
        end else begin
            if (w_cmd_hs) begin
                stat_cmds <= stat_cmds + 32'd1;
            end
            if (w_wr_hs) begin
                stat_wr_words <= stat_wr_words + 32'd1;
            end
            if (read_enable && read_ready) begin
                stat_rd_words <= stat_rd_words + 32'd1;
            end
        end
    end
`endif

endmodule : mem_cmd_responder

// File: tb/tb_mem_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_cmd_responder
// Scoreboard bench for mem_cmd_responder with a behavioural SRAM of the same
// read latency. Stimulus pushes expected SRAM writes, read issue addresses and
// read words into queues; a negedge monitor pops and compares them whenever
// the DUT strobes the SRAM or presents a read word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_cmd_responder;

    localparam int MEM_WIDTH    = 32;
    localparam int ADDR_WIDTH   = 18;
    localparam int READ_LATENCY = 2;
    localparam int RD_BUF_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_ready;
    logic                  cmd_enable;
    logic [64:0]           cmd_data;
    logic                  write_ready;
    logic                  write_enable;
    logic [MEM_WIDTH-1:0]  write_data;
    logic                  read_ready;
    logic                  read_enable;
    logic [MEM_WIDTH-1:0]  read_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [MEM_WIDTH-1:0]  mem_wr_data;
    logic                  mem_rd_en;
    logic [MEM_WIDTH-1:0]  mem_rd_data;
    logic                  busy;
`ifdef MEM_CMD_RESPONDER_STATS_EN
    logic [31:0]           stat_cmds;
    logic [31:0]           stat_wr_words;
    logic [31:0]           stat_rd_words;
`endif

    always #5 clk = ~clk;

    mem_cmd_responder #(
        .MEM_WIDTH    (MEM_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .RD_BUF_DEPTH (RD_BUF_DEPTH)
    ) dut (
`ifdef MEM_CMD_RESPONDER_STATS_EN
        .stat_cmds     (stat_cmds),
        .stat_wr_words (stat_wr_words),
        .stat_rd_words (stat_rd_words),
`endif
        .clk          (clk),
        .reset        (reset),
        .cmd_ready    (cmd_ready),
        .cmd_enable   (cmd_enable),
        .cmd_data     (cmd_data),
        .write_ready  (write_ready),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_ready   (read_ready),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy)
    );

    // Behavioural SRAM: write on the strobe edge, read data valid two edges
    // after the read strobe.
    logic [MEM_WIDTH-1:0] sram [0:(1<<ADDR_WIDTH)-1];
    logic [MEM_WIDTH-1:0] sram_p0;
    logic [MEM_WIDTH-1:0] sram_p1;

    always @(posedge clk) begin
        if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
        sram_p0 <= mem_rd_en ? sram[mem_addr] : 32'hDEAD_BEEF;
        sram_p1 <= sram_p0;
    end
    assign mem_rd_data = sram_p1;

    // Scoreboard
    logic [ADDR_WIDTH+MEM_WIDTH-1:0] exp_wr_q[$];
    logic [ADDR_WIDTH-1:0]           exp_rd_addr_q[$];
    logic [MEM_WIDTH-1:0]            exp_rd_q[$];
    logic [ADDR_WIDTH+MEM_WIDTH-1:0] mon_wr;
    logic [ADDR_WIDTH-1:0]           mon_addr;
    logic [MEM_WIDTH-1:0]            mon_data;
    int checks       = 0;
    int errors       = 0;
    int rd_issue_cnt = 0;
    int base_issue;
    int n_wait;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr: actual addr 0x%0h data 0x%0h required no write", mem_addr, mem_wr_data);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(mon_wr[ADDR_WIDTH+MEM_WIDTH-1:MEM_WIDTH]));
                    check("wr_data", 64'(mem_wr_data), 64'(mon_wr[MEM_WIDTH-1:0]));
                end
            end
            if (mem_rd_en) begin
                rd_issue_cnt++;
                if (exp_rd_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_issue: actual addr 0x%0h required no read", mem_addr);
                end else begin
                    mon_addr = exp_rd_addr_q.pop_front();
                    check("rd_addr", 64'(mem_addr), 64'(mon_addr));
                end
            end
            if (read_enable && read_ready) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_data: actual 0x%0h required no word", read_data);
                end else begin
                    mon_data = exp_rd_q.pop_front();
                    check("rd_data", 64'(read_data), 64'(mon_data));
                end
            end
        end
    end

    // Stimulus runs at posedge + 1, away from both the DUT edge and the monitor.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] len, input logic rnw);
        int t = 0;
        cmd_enable = 1'b1;
        cmd_data   = {a, len, rnw};
        while (!cmd_ready && t < 200) begin step(); t++; end
        check("cmd_ready_seen", 64'(cmd_ready), 64'd1);
        step();
        cmd_enable = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input int n, input logic [31:0] base);
        send_cmd(a, 32'(n), 1'b0);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            write_enable = 1'b1;
            write_data   = base + 32'(i);
            exp_wr_q.push_back({ADDR_WIDTH'(a + 32'(i)), base + 32'(i)});
            while (!write_ready && t < 200) begin step(); t++; end
            check("write_ready_seen", 64'(write_ready), 64'd1);
            step();
        end
        write_enable = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            exp_rd_addr_q.push_back(ADDR_WIDTH'(a + 32'(i)));
            exp_rd_q.push_back(base + 32'(i));
        end
        send_cmd(a, 32'(n), 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) && t < 1000) begin
            step(); t++;
        end
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({name, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
    endtask

    task automatic check_all_low(input string name);
        check({name, "_cmd_ready"},   64'(cmd_ready),   64'd0);
        check({name, "_write_ready"}, 64'(write_ready), 64'd0);
        check({name, "_read_enable"}, 64'(read_enable), 64'd0);
        check({name, "_read_data"},   64'(read_data),   64'd0);
        check({name, "_mem_wr_en"},   64'(mem_wr_en),   64'd0);
        check({name, "_mem_rd_en"},   64'(mem_rd_en),   64'd0);
        check({name, "_mem_addr"},    64'(mem_addr),    64'd0);
        check({name, "_busy"},        64'(busy),        64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        cmd_enable   = 1'b0;
        cmd_data     = '0;
        write_enable = 1'b0;
        write_data   = '0;
        read_ready   = 1'b1;
        repeat (3) step();
        check_all_low("rst");
        reset = 1'b0;
        step();
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write then read back 0x10..0x13.
        do_write(32'h10, 4, 32'hA0);
        do_read(32'h10, 4, 32'hA0);
        wait_idle("wr_rd");
`ifdef MEM_CMD_RESPONDER_STATS_EN
        check("stat_cmds",     64'(stat_cmds),     64'd2);
        check("stat_wr_words", 64'(stat_wr_words), 64'd4);
        check("stat_rd_words", 64'(stat_rd_words), 64'd4);
`endif

        // Backpressure: 16-word read with read_ready low for 20 cycles.
        do_write(32'h100, 16, 32'hB00);
        wait_idle("bp_fill");
        read_ready = 1'b0;
        base_issue = rd_issue_cnt;
        do_read(32'h100, 16, 32'hB00);
        repeat (20) step();
        check("bp_issued",      64'(rd_issue_cnt - base_issue), 64'(RD_BUF_DEPTH));
        check("bp_read_enable", 64'(read_enable), 64'd1);
        check("bp_head",        64'(read_data),   64'h0000_0B00);
        check("bp_busy",        64'(busy),        64'd1);
        read_ready = 1'b1;
        wait_idle("bp");
        check("bp_total", 64'(rd_issue_cnt - base_issue), 64'd16);

        // Zero-length read: consumed with no SRAM activity.
        base_issue = rd_issue_cnt;
        send_cmd(32'h20, 32'd0, 1'b1);
        check("zl_cmd_ready", 64'(cmd_ready), 64'd1);
        check("zl_busy",      64'(busy),      64'd0);
        repeat (3) step();
        check("zl_no_issue", 64'(rd_issue_cnt - base_issue), 64'd0);

        // Address wrap at the top of the SRAM.
        do_write(32'h3FFFE, 4, 32'hC0);
        do_read(32'h3FFFE, 4, 32'hC0);
        wait_idle("wrap");

        // Upper command address bits are discarded: 0xFFFC0011 -> 0x11.
        do_read(32'hFFFC_0011, 1, 32'hA1);
        wait_idle("trunc");

        // Reset in the middle of an 8-word read after 3 issues.
        read_ready = 1'b0;
        base_issue = rd_issue_cnt;
        for (int i = 0; i < 8; i++) exp_rd_addr_q.push_back(ADDR_WIDTH'(32'h10 + 32'(i)));
        send_cmd(32'h10, 32'd8, 1'b1);
        n_wait = 0;
        while ((rd_issue_cnt - base_issue) < 3 && n_wait < 100) begin step(); n_wait++; end
        check("mid_issued", 64'(rd_issue_cnt - base_issue), 64'd3);
        reset = 1'b1;
        #1;
        check_all_low("mid_rst");
        exp_rd_addr_q.delete();
        repeat (3) step();
        reset      = 1'b0;
        read_ready = 1'b1;
        step();
        do_read(32'h10, 1, 32'hA0);
        wait_idle("post_rst");
        repeat (5) step();
        check("post_rst_no_stale", 64'(read_enable), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_cmd_responder
